// File: rtl/dnoc_itf_dma_rd.sv
// -----------------------------------------------------------------------------
// dnoc_itf_dma_rd
// Read-side DMA channel of the dnoc interface. A read-out command from the NoC
// is accepted in IDLE, the configuration is latched, and L2 dmem is walked with
// a 4-level loop/gap address pattern. Each 256-bit beat read from L2 is pushed
// into a small credit-controlled FIFO that absorbs the 1-cycle SRAM latency and
// NoC back-pressure, then streamed out with valid/ready.
//
// Optional feature (compile-time macro): DNOC_ITF_DMA_RD_LAST_EN
//   defined   : adds output dma_rd_noc_out_last, high with valid on the final
//               beat of a transfer (one side-bit stored per FIFO entry)
//   undefined : no last port, no side-bit
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   noc_cmd_dma_rd_req / _gnt       command handshake (gnt combinational, IDLE)
//   n_cfg_d_r_ram_base_addr         L2 start address
//   n_cfg_d_r_ram_total_lenth       beats minus one
//   n_cfg_d_r_loop_lenth            4 x 13-bit per-level count minus one (lvl0 LSBs)
//   n_cfg_d_r_loop_gap              4 x 13-bit per-level address stride
//   L2_dmem_dma_rd_en/_addr         SRAM read strobe and address
//   L2_dmem_dma_rd_gnt              L2 arbiter accepted the read this cycle
//   L2_dmem_dma_rd_data             read data, valid 1 cycle after acceptance
//   dma_rd_noc_out_data/_valid      beat to NoC
//   dma_rd_noc_out_ready            NoC accepts beat
//   d_r_transaction_done            one-cycle completion pulse
// -----------------------------------------------------------------------------
module dnoc_itf_dma_rd #(
   parameter int DATA_W     = 256,
   parameter int ADDR_W     = 13,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                noc_cmd_dma_rd_req,
   output logic                noc_cmd_dma_rd_gnt,
   input  logic [ADDR_W-1:0]   n_cfg_d_r_ram_base_addr,
   input  logic [ADDR_W-1:0]   n_cfg_d_r_ram_total_lenth,
   input  logic [4*ADDR_W-1:0] n_cfg_d_r_loop_lenth,
   input  logic [4*ADDR_W-1:0] n_cfg_d_r_loop_gap,
   output logic                L2_dmem_dma_rd_en,
   output logic [ADDR_W-1:0]   L2_dmem_dma_rd_addr,
   input  logic                L2_dmem_dma_rd_gnt,
   input  logic [DATA_W-1:0]   L2_dmem_dma_rd_data,
   output logic [DATA_W-1:0]   dma_rd_noc_out_data,
   output logic                dma_rd_noc_out_valid,
   input  logic                dma_rd_noc_out_ready,
`ifdef DNOC_ITF_DMA_RD_LAST_EN
   output logic                dma_rd_noc_out_last,
`endif
   output logic                d_r_transaction_done
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
   localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RD    = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_base, r_total, r_issue, r_addr;
   logic [ADDR_W-1:0]   r_len   [4];
   logic [ADDR_W-1:0]   r_gap   [4];
   logic [ADDR_W-1:0]   r_c     [4];
   logic [ADDR_W-1:0]   w_c_nxt [4];
   logic [3:0]          w_wrap;
   logic                w_inc1, w_inc2, w_inc3;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic                r_inflight;
   logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
   logic [PW-1:0]       r_wptr, r_rptr;
   logic [CW-1:0]       r_count, w_credit;
   logic                w_gnt, w_done, w_rd_en, w_accept, w_pop, w_push, w_is_last;
`ifdef DNOC_ITF_DMA_RD_LAST_EN
   logic                r_inflight_last;
   logic                r_mem_last [FIFO_DEPTH];
`endif

   // One loop-level step: hold, increment, or wrap back to zero at its limit.
   function automatic logic [ADDR_W-1:0] next_cnt(input logic [ADDR_W-1:0] cur,
                                                  input logic wrap, input logic inc);
      logic [ADDR_W-1:0] res;
      if (!inc) begin
         res = cur;
      end else if (wrap) begin
         res = '0;
      end else begin
         res = cur + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

   // Credit counts buffered beats plus the read in flight, minus a beat leaving
   // this cycle, so a read is only issued when its data is sure to have a slot.
   assign w_pop     = dma_rd_noc_out_valid & dma_rd_noc_out_ready;
   assign w_push    = r_inflight;
   assign w_credit  = r_count + CW'(r_inflight) - CW'(w_pop);
   assign w_rd_en   = (r_state == ST_RD) && (w_credit < DEPTH_C);
   assign w_accept  = w_rd_en & L2_dmem_dma_rd_gnt;
   assign w_is_last = (r_issue == r_total);

   // Carry chain: a level advances only when all inner levels wrap together.
   assign w_inc1 = w_accept & w_wrap[0];
   assign w_inc2 = w_inc1   & w_wrap[1];
   assign w_inc3 = w_inc2   & w_wrap[2];

   // Next loop counters and the address they select (13-bit wrap is intended).
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_wrap[k] = (r_c[k] == r_len[k]);
      end
      w_c_nxt[0] = next_cnt(r_c[0], w_wrap[0], w_accept);
      w_c_nxt[1] = next_cnt(r_c[1], w_wrap[1], w_inc1);
      w_c_nxt[2] = next_cnt(r_c[2], w_wrap[2], w_inc2);
      w_c_nxt[3] = next_cnt(r_c[3], w_wrap[3], w_inc3);
      w_addr_nxt = r_base;
      for (int k = 0; k < 4; k++) begin
         w_addr_nxt = w_addr_nxt + w_c_nxt[k] * r_gap[k];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, command grant and completion pulse.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt       = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (noc_cmd_dma_rd_req) begin
               w_gnt       = 1'b1;
               w_state_nxt = ST_RD;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RD: begin
            if (w_accept && w_is_last) begin
               w_state_nxt = ST_DRAIN;
            end else begin
               w_state_nxt = ST_RD;
            end
         end
         ST_DRAIN: begin
            if ((r_count == '0) && !r_inflight) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DRAIN;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Configuration latch, loop counters, issue counter and read address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base  <= '0;
         r_total <= '0;
         r_issue <= '0;
         r_addr  <= '0;
         for (int k = 0; k < 4; k++) begin
            r_len[k] <= '0;
            r_gap[k] <= '0;
            r_c[k]   <= '0;
         end
      end else if (w_gnt) begin
         r_base  <= n_cfg_d_r_ram_base_addr;
         r_total <= n_cfg_d_r_ram_total_lenth;
         r_issue <= '0;
         r_addr  <= n_cfg_d_r_ram_base_addr;
         for (int k = 0; k < 4; k++) begin
            r_len[k] <= n_cfg_d_r_loop_lenth[k*ADDR_W +: ADDR_W];
            r_gap[k] <= n_cfg_d_r_loop_gap[k*ADDR_W +: ADDR_W];
            r_c[k]   <= '0;
         end
      end else if (w_accept) begin
         r_issue <= r_issue + {{(ADDR_W-1){1'b0}}, 1'b1};
         r_addr  <= w_addr_nxt;
         for (int k = 0; k < 4; k++) begin
            r_c[k] <= w_c_nxt[k];
         end
      end
   end

   // In-flight flag: L2 data for an accepted read arrives on the next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= 1'b0;
`ifdef DNOC_ITF_DMA_RD_LAST_EN
         r_inflight_last <= 1'b0;
`endif
      end else begin
         r_inflight <= w_accept;
`ifdef DNOC_ITF_DMA_RD_LAST_EN
         r_inflight_last <= w_accept & w_is_last;
`endif
      end
   end

   // Output FIFO: push of returning data and pop to the NoC may coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
`ifdef DNOC_ITF_DMA_RD_LAST_EN
            r_mem_last[i] <= 1'b0;
`endif
         end
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= L2_dmem_dma_rd_data;
`ifdef DNOC_ITF_DMA_RD_LAST_EN
            r_mem_last[r_wptr] <= r_inflight_last;
`endif
            r_wptr <= (r_wptr == LAST_IDX) ? '0 : r_wptr + {{(PW-1){1'b0}}, 1'b1};
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == LAST_IDX) ? '0 : r_rptr + {{(PW-1){1'b0}}, 1'b1};
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
            default: r_count <= r_count;
         endcase
      end
   end

   assign noc_cmd_dma_rd_gnt    = w_gnt & rst_n;
   assign L2_dmem_dma_rd_en     = w_rd_en;
   assign L2_dmem_dma_rd_addr   = w_rd_en ? r_addr : '0;
   assign dma_rd_noc_out_valid  = (r_count != '0);
   assign dma_rd_noc_out_data   = r_mem[r_rptr];
   assign d_r_transaction_done  = w_done;
`ifdef DNOC_ITF_DMA_RD_LAST_EN
   assign dma_rd_noc_out_last   = (r_count != '0) & r_mem_last[r_rptr];
`endif

endmodule

// File: tb/tb_dnoc_itf_dma_rd.sv
// -----------------------------------------------------------------------------
// Testbench for dnoc_itf_dma_rd. Directed and randomized transfers against a
// reference model: expected addresses come from a mixed-radix decomposition of
// the beat index, expected timing from the read-to-valid latency and the FIFO
// credit rule, and expected data from an address-tagged L2 model.
// -----------------------------------------------------------------------------
module tb_dnoc_itf_dma_rd;
   localparam int DATA_W     = 256;
   localparam int ADDR_W     = 13;
   localparam int FIFO_DEPTH = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                req;
   logic                gnt;
   logic [ADDR_W-1:0]   cfg_base, cfg_total;
   logic [ADDR_W-1:0]   cfg_len [4];
   logic [ADDR_W-1:0]   cfg_gap [4];
   logic [4*ADDR_W-1:0] len_bus, gap_bus;
   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic                l2_gnt;
   logic [DATA_W-1:0]   rd_data;
   logic [DATA_W-1:0]   out_data;
   logic                out_valid;
   logic                out_ready;
   logic                done;
`ifdef DNOC_ITF_DMA_RD_LAST_EN
   logic                out_last;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   int          done_t;
   logic [10:0] salt;

   always #5 clk = ~clk;

   assign len_bus = {cfg_len[3], cfg_len[2], cfg_len[1], cfg_len[0]};
   assign gap_bus = {cfg_gap[3], cfg_gap[2], cfg_gap[1], cfg_gap[0]};

   dnoc_itf_dma_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk                        (clk),
      .rst_n                      (rst_n),
      .noc_cmd_dma_rd_req         (req),
      .noc_cmd_dma_rd_gnt         (gnt),
      .n_cfg_d_r_ram_base_addr    (cfg_base),
      .n_cfg_d_r_ram_total_lenth  (cfg_total),
      .n_cfg_d_r_loop_lenth       (len_bus),
      .n_cfg_d_r_loop_gap         (gap_bus),
      .L2_dmem_dma_rd_en          (rd_en),
      .L2_dmem_dma_rd_addr        (rd_addr),
      .L2_dmem_dma_rd_gnt         (l2_gnt),
      .L2_dmem_dma_rd_data        (rd_data),
      .dma_rd_noc_out_data        (out_data),
      .dma_rd_noc_out_valid       (out_valid),
      .dma_rd_noc_out_ready       (out_ready),
`ifdef DNOC_ITF_DMA_RD_LAST_EN
      .dma_rd_noc_out_last        (out_last),
`endif
      .d_r_transaction_done       (done)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Address of beat i: the beat index written in mixed radix (len_k+1).
   function automatic logic [ADDR_W-1:0] model_addr(input int i);
      int rem = i;
      int a   = int'(cfg_base);
      for (int k = 0; k < 4; k++) begin
         int r = int'(cfg_len[k]) + 1;
         a   = a + (rem % r) * int'(cfg_gap[k]);
         rem = rem / r;
      end
      return ADDR_W'(a);
   endfunction

   // L2 content model: every word is tagged with its address.
   function automatic logic [DATA_W-1:0] beat(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] d;
      for (int j = 0; j < 8; j++) begin
         d[j*32 +: 32] = {a, salt, 8'(j)};
      end
      return d;
   endfunction

   function automatic logic [DATA_W-1:0] junk();
      logic [DATA_W-1:0] d;
      for (int j = 0; j < 8; j++) begin
         d[j*32 +: 32] = $urandom;
      end
      return d;
   endfunction

   task automatic set_cfg(input int base, input int total, input int l0, input int g0,
                          input int l1, input int g1);
      cfg_base  = ADDR_W'(base);
      cfg_total = ADDR_W'(total);
      cfg_len[0] = ADDR_W'(l0); cfg_gap[0] = ADDR_W'(g0);
      cfg_len[1] = ADDR_W'(l1); cfg_gap[1] = ADDR_W'(g1);
      cfg_len[2] = '0;          cfg_gap[2] = '0;
      cfg_len[3] = '0;          cfg_gap[3] = '0;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_gnt"},   gnt, 1'b0);
      check({tag, "_rd_en"}, rd_en, 1'b0);
      check({tag, "_addr"},  rd_addr, '0);
      check({tag, "_valid"}, out_valid, 1'b0);
      check({tag, "_data"},  out_data, '0);
      check({tag, "_done"},  done, 1'b0);
`ifdef DNOC_ITF_DMA_RD_LAST_EN
      check({tag, "_last"},  out_last, 1'b0);
`endif
   endtask

   // One transfer, cycle 0 = command cycle.
   // gmode: 0 L2 gnt always, 1 pattern 1,0,0,1, 2 random
   // rmode: 0 ready always, 1 low for 5 cycles after first valid, 2 random, 3 never
   task automatic run(input string name, input int gmode, input int rmode, input bit abort2);
      logic [ADDR_W-1:0] exp_a[$];
      int   acc_t[$];
      int   n_acc = 0, n_pop = 0, last_pop_t = -10, low_left = 5, avail;
      bit   prev_acc = 1'b0, first_valid = 1'b0, done_seen = 1'b0;
      bit   exp_valid, exp_en, exp_done, pop;
      logic [ADDR_W-1:0] prev_addr = '0;
      int   total = int'(cfg_total);

      salt = 11'($urandom);
      for (int i = 0; i <= total; i++) exp_a.push_back(model_addr(i));
      done_t = -1;

      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         req = (t == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
         case (gmode)
            0:       l2_gnt = 1'b1;
            1:       l2_gnt = ((t % 4) == 0) || ((t % 4) == 3);
            default: l2_gnt = 1'($urandom_range(0, 1));
         endcase
         case (rmode)
            0:       out_ready = 1'b1;
            1: begin
               if (first_valid && low_left > 0) begin
                  out_ready = 1'b0;
                  low_left--;
               end else begin
                  out_ready = 1'b1;
               end
            end
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
         rd_data = prev_acc ? beat(prev_addr) : junk();
         #1;

         if (t == 0) check({name, "_gnt"}, gnt, 1'b1);
         else if (req) check({name, "_gnt_busy"}, gnt, 1'b0);

         avail = 0;
         foreach (acc_t[i]) if (acc_t[i] <= t - 2) avail++;
         avail     = avail - n_pop;
         exp_valid = (avail > 0);
         check({name, "_valid"}, out_valid, exp_valid);
         pop    = exp_valid & out_ready;
         exp_en = (t >= 1) && (n_acc <= total) && ((n_acc - n_pop - int'(pop)) < FIFO_DEPTH);
         check({name, "_rd_en"}, rd_en, exp_en);
         if (exp_en) check({name, "_addr"}, rd_addr, exp_a[n_acc]);
         if (exp_valid) begin
            first_valid = 1'b1;
            check({name, "_data"}, out_data, beat(exp_a[n_pop]));
`ifdef DNOC_ITF_DMA_RD_LAST_EN
            check({name, "_last"}, out_last, (n_pop == total));
`endif
         end
         exp_done = (n_pop == total + 1) && (t == last_pop_t + 1);
         check({name, "_done"}, done, exp_done);

         if (abort2 && avail == 2) begin
            rst_n = 1'b0;
            req   = 1'b0;
            #1;
            check_zero_outputs({name, "_rst"});
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end

         prev_acc = exp_en & l2_gnt;
         if (prev_acc) begin
            acc_t.push_back(t);
            prev_addr = exp_a[n_acc];
            n_acc++;
         end
         if (pop) begin
            n_pop++;
            if (n_pop == total + 1) last_pop_t = t;
         end
         if (done) begin
            done_seen = 1'b1;
            done_t    = t;
            break;
         end
      end
      check({name, "_completed"}, done_seen, 1'b1);
      check({name, "_beats"}, n_pop, total + 1);
   endtask

   initial begin
      rst_n = 1'b0; req = 1'b0; l2_gnt = 1'b0; out_ready = 1'b0; rd_data = '0;
      set_cfg(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      check_zero_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      set_cfg(13'h100, 7, 7, 1, 0, 0);
      run("linear", 0, 0, 1'b0);
      check("linear_done_cycle", done_t, 11);

      set_cfg(0, 5, 2, 1, 1, 16);
      run("pattern2d", 0, 0, 1'b0);

      set_cfg(13'h040, 7, 7, 1, 0, 0);
      run("backpressure", 0, 1, 1'b0);

      set_cfg(13'h200, 9, 3, 2, 2, 32);
      run("l2_stall", 1, 0, 1'b0);

      set_cfg(13'h1FFF, 1, 1, 1, 0, 0);
      run("wrap", 0, 0, 1'b0);

      set_cfg(13'h0AA, 0, 0, 1, 0, 0);
      run("single", 0, 0, 1'b0);
      check("single_done_cycle", done_t, 4);

      for (int n = 0; n < 6; n++) begin
         cfg_base  = ADDR_W'($urandom);
         cfg_total = ADDR_W'($urandom_range(0, 30));
         for (int k = 0; k < 4; k++) begin
            cfg_len[k] = ADDR_W'($urandom_range(0, 3));
            cfg_gap[k] = ADDR_W'($urandom);
         end
         run("random", 2, 2, 1'b0);
      end

      set_cfg(13'h300, 7, 7, 1, 0, 0);
      run("midreset", 0, 3, 1'b1);
      set_cfg(13'h310, 3, 3, 1, 0, 0);
      run("after_reset", 0, 0, 1'b0);

      req = 1'b0;
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
